// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller: scoreboard of downstream producers, operand forwarding
// selects, load-use stalls, multi-cycle fetch flush and saturating event counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FWD_DEPTH    = 2,
  parameter int unsigned LOAD_LAT     = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic [REG_AW-1:0]                  issue_rs1,
  input  logic [REG_AW-1:0]                  issue_rs2,
  input  logic                               issue_rs1_used,
  input  logic                               issue_rs2_used,
  input  logic [REG_AW-1:0]                  issue_rd,
  input  logic                               issue_reg_wr,
  input  logic                               issue_is_load,
  input  logic                               br_taken,
  output logic                               stall,
  output logic                               flush,
  output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_sel_a,
  output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_sel_b,
  output logic [CNT_W-1:0]                   stall_count,
  output logic [CNT_W-1:0]                   flush_count
);

  localparam int unsigned FSW = $clog2(FWD_DEPTH + 1);
  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // Index 0 holds stage 1 (nearest to execute).
  logic [FWD_DEPTH-1:0]             sb_valid_q, sb_valid_d;
  logic [FWD_DEPTH-1:0]             sb_load_q, sb_load_d;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] sb_rd_q, sb_rd_d;

  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_evt_q;

  logic flushing, entry_valid;
  logic cand_a, cand_b, hit_a, hit_b, haz_a, haz_b;

  assign cand_a = issue_valid & issue_rs1_used & (issue_rs1 != '0);
  assign cand_b = issue_valid & issue_rs2_used & (issue_rs2 != '0);

  // Ascending scan with a hit flag so the nearest producer wins.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    hit_a     = 1'b0;
    hit_b     = 1'b0;
    haz_a     = 1'b0;
    haz_b     = 1'b0;
    for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
      if (!hit_a && cand_a && sb_valid_q[k-1] && (sb_rd_q[k-1] == issue_rs1)) begin
        hit_a = 1'b1;
        if (sb_load_q[k-1] && (k < int'(LOAD_LAT))) haz_a = 1'b1;
        else                                          fwd_sel_a = FSW'(k);
      end
      if (!hit_b && cand_b && sb_valid_q[k-1] && (sb_rd_q[k-1] == issue_rs2)) begin
        hit_b = 1'b1;
        if (sb_load_q[k-1] && (k < int'(LOAD_LAT))) haz_b = 1'b1;
        else                                          fwd_sel_b = FSW'(k);
      end
    end
  end

  assign stall       = haz_a | haz_b;
  assign flushing    = (flush_cnt_q != '0);
  // Gated by reset so a taken branch cannot flush while the core is held.
  assign flush       = rst & ((br_taken & ~stall) | flushing);
  assign entry_valid = issue_valid & issue_reg_wr & (issue_rd != '0) & ~stall & ~flushing;

  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_load_d  = sb_load_q;
    sb_rd_d    = sb_rd_q;
    for (int k = int'(FWD_DEPTH) - 1; k >= 1; k--) begin
      sb_valid_d[k] = sb_valid_q[k-1];
      sb_load_d[k]  = sb_load_q[k-1];
      sb_rd_d[k]    = sb_rd_q[k-1];
    end
    sb_valid_d[0] = entry_valid;
    sb_load_d[0]  = issue_is_load;
    sb_rd_d[0]    = issue_rd;
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (br_taken && !stall) flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
    else if (flushing)      flush_cnt_d = flush_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid_q  <= '0;
      sb_load_q   <= '0;
      sb_rd_q     <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_evt_q <= '0;
    end else begin
      sb_valid_q  <= sb_valid_d;
      sb_load_q   <= sb_load_d;
      sb_rd_q     <= sb_rd_d;
      flush_cnt_q <= flush_cnt_d;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_evt_q != '1)) flush_evt_q <= flush_evt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_evt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: default, 3-cycle flush, 4-bit counter and
// single-stage legacy instances share one stimulus stream.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid, issue_rs1_used, issue_rs2_used, issue_reg_wr, issue_is_load, br_taken;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;

  logic        stall0, flush0, stall_f, flush_f, stall_s, flush_s, stall_l, flush_l;
  logic [1:0]  sel_a0, sel_b0, sel_a_f, sel_b_f, sel_a_s, sel_b_s;
  logic [0:0]  sel_a_l, sel_b_l;
  logic [15:0] scnt0, fcnt0, scnt_f, fcnt_f, scnt_l, fcnt_l;
  logic [3:0]  scnt_s, fcnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit dut0 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_reg_wr(issue_reg_wr), .issue_is_load(issue_is_load),
    .br_taken(br_taken), .stall(stall0), .flush(flush0), .fwd_sel_a(sel_a0),
    .fwd_sel_b(sel_b0), .stall_count(scnt0), .flush_count(fcnt0)
  );

  hazard_ctrl_unit #(.FLUSH_CYCLES(3)) dut_f (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_reg_wr(issue_reg_wr), .issue_is_load(issue_is_load),
    .br_taken(br_taken), .stall(stall_f), .flush(flush_f), .fwd_sel_a(sel_a_f),
    .fwd_sel_b(sel_b_f), .stall_count(scnt_f), .flush_count(fcnt_f)
  );

  hazard_ctrl_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_reg_wr(issue_reg_wr), .issue_is_load(issue_is_load),
    .br_taken(br_taken), .stall(stall_s), .flush(flush_s), .fwd_sel_a(sel_a_s),
    .fwd_sel_b(sel_b_s), .stall_count(scnt_s), .flush_count(fcnt_s)
  );

  hazard_ctrl_unit #(.FWD_DEPTH(1), .LOAD_LAT(1)) dut_l (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_reg_wr(issue_reg_wr), .issue_is_load(issue_is_load),
    .br_taken(br_taken), .stall(stall_l), .flush(flush_l), .fwd_sel_a(sel_a_l),
    .fwd_sel_b(sel_b_l), .stall_count(scnt_l), .flush_count(fcnt_l)
  );

  task automatic set_issue(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                           input logic wr, input logic ld);
    issue_valid = v;   issue_rs1 = rs1; issue_rs1_used = u1; issue_rs2 = rs2;
    issue_rs2_used = u2; issue_rd = rd; issue_reg_wr = wr;   issue_is_load = ld;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    br_taken = 1'b0;
    set_issue(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    br_taken = 1'b1;
    set_issue(1, 5, 1, 5, 1, 5, 1, 0);
    tick(); tick();
    n_checks++; if (flush0 !== 1'b0) begin n_fail++; $display("FAIL rst_flush got %0d want 0", flush0); end
    n_checks++; if (flush_f !== 1'b0) begin n_fail++; $display("FAIL rst_flush_f got %0d want 0", flush_f); end
    n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0d want 0", stall0); end
    n_checks++; if (sel_a0 !== 2'd0) begin n_fail++; $display("FAIL rst_sel_a got %0d want 0", sel_a0); end
    n_checks++; if (scnt0 !== 16'd0 || fcnt0 !== 16'd0) begin
      n_fail++; $display("FAIL rst_counters got %0d/%0d want 0/0", scnt0, fcnt0); end
    br_taken = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if ({stall0, flush0, sel_a0, sel_b0} !== 6'd0) begin
      n_fail++; $display("FAIL rst_release got %0h want 0", {stall0, flush0, sel_a0, sel_b0}); end
    // Reset in flight: load pending, then asynchronously cleared.
    set_issue(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    set_issue(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    n_checks++; if (stall0 !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall got %0d want 1", stall0); end
    rst = 1'b0;
    #1;
    n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL mid_async_stall got %0d want 0", stall0); end
    rst = 1'b1;
    #1;
    n_checks++; if (stall0 !== 1'b0 || sel_a0 !== 2'd0) begin
      n_fail++; $display("FAIL mid_release got %0d/%0d want 0/0", stall0, sel_a0); end
  endtask

  task automatic test_alu_chain;
    do_reset();
    set_issue(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    set_issue(1, 5, 1, 5, 1, 0, 0, 0);
    #1;
    n_checks++; if (sel_a0 !== 2'd1) begin n_fail++; $display("FAIL alu_k1_a got %0d want 1", sel_a0); end
    n_checks++; if (sel_b0 !== 2'd1) begin n_fail++; $display("FAIL alu_k1_b got %0d want 1", sel_b0); end
    tick();
    n_checks++; if (sel_a0 !== 2'd2) begin n_fail++; $display("FAIL alu_k2_a got %0d want 2", sel_a0); end
    tick();
    n_checks++; if (sel_a0 !== 2'd0) begin n_fail++; $display("FAIL alu_k3_a got %0d want 0", sel_a0); end
    // Two producers of x5: nearest wins.
    do_reset();
    set_issue(1, 0, 0, 0, 0, 5, 1, 0);
    tick(); tick();
    set_issue(1, 5, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (sel_a0 !== 2'd1) begin n_fail++; $display("FAIL alu_nearest got %0d want 1", sel_a0); end
    n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL alu_nostall got %0d want 0", stall0); end
  endtask

  task automatic test_load_use;
    do_reset();
    set_issue(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    set_issue(1, 0, 0, 7, 1, 8, 1, 0);
    #1;
    n_checks++; if (stall0 !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %0d want 1", stall0); end
    n_checks++; if (sel_b0 !== 2'd0) begin n_fail++; $display("FAIL lu_sel_b got %0d want 0", sel_b0); end
    n_checks++; if (stall_l !== 1'b0 || sel_b_l !== 1'b1) begin
      n_fail++; $display("FAIL lu_legacy got %0d/%0d want 0/1", stall_l, sel_b_l); end
    tick();
    n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL lu_release got %0d want 0", stall0); end
    n_checks++; if (sel_b0 !== 2'd2) begin n_fail++; $display("FAIL lu_fwd got %0d want 2", sel_b0); end
    tick();
    n_checks++; if (scnt0 !== 16'd1) begin n_fail++; $display("FAIL lu_count got %0d want 1", scnt0); end
  endtask

  task automatic test_x0_unused;
    do_reset();
    set_issue(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    set_issue(1, 0, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (sel_a0 !== 2'd0) begin n_fail++; $display("FAIL x0_sel_a got %0d want 0", sel_a0); end
    set_issue(1, 0, 0, 0, 0, 3, 1, 1);
    tick();
    set_issue(1, 9, 1, 3, 0, 0, 0, 0);
    #1;
    n_checks++; if (sel_b0 !== 2'd0 || stall0 !== 1'b0) begin
      n_fail++; $display("FAIL unused_rs2 got %0d/%0d want 0/0", sel_b0, stall0); end
    set_issue(0, 3, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (sel_a0 !== 2'd0 || stall0 !== 1'b0) begin
      n_fail++; $display("FAIL invalid_issue got %0d/%0d want 0/0", sel_a0, stall0); end
  endtask

  task automatic test_multi_flush;
    do_reset();
    br_taken = 1'b1;
    set_issue(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (flush_f !== 1'b1) begin n_fail++; $display("FAIL mf_c0 got %0d want 1", flush_f); end
    tick();
    br_taken = 1'b0;
    set_issue(1, 0, 0, 0, 0, 10, 1, 0);
    #1;
    n_checks++; if (flush_f !== 1'b1) begin n_fail++; $display("FAIL mf_c1 got %0d want 1", flush_f); end
    n_checks++; if (flush0 !== 1'b0) begin n_fail++; $display("FAIL mf_single got %0d want 0", flush0); end
    tick();
    n_checks++; if (flush_f !== 1'b1) begin n_fail++; $display("FAIL mf_c2 got %0d want 1", flush_f); end
    tick();
    set_issue(1, 10, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (flush_f !== 1'b0) begin n_fail++; $display("FAIL mf_c3 got %0d want 0", flush_f); end
    n_checks++; if (sel_a_f !== 2'd0) begin n_fail++; $display("FAIL mf_nofwd got %0d want 0", sel_a_f); end
    n_checks++; if (fcnt_f !== 16'd3) begin n_fail++; $display("FAIL mf_count got %0d want 3", fcnt_f); end
    // Re-trigger in the second flush cycle.
    do_reset();
    br_taken = 1'b1;
    #1;
    tick();
    #1;
    n_checks++; if (flush_f !== 1'b1) begin n_fail++; $display("FAIL mr_c1 got %0d want 1", flush_f); end
    tick();
    br_taken = 1'b0;
    #1;
    n_checks++; if (flush_f !== 1'b1) begin n_fail++; $display("FAIL mr_c2 got %0d want 1", flush_f); end
    tick();
    n_checks++; if (flush_f !== 1'b1) begin n_fail++; $display("FAIL mr_c3 got %0d want 1", flush_f); end
    tick();
    n_checks++; if (flush_f !== 1'b0) begin n_fail++; $display("FAIL mr_c4 got %0d want 0", flush_f); end
    n_checks++; if (fcnt_f !== 16'd4) begin n_fail++; $display("FAIL mr_count got %0d want 4", fcnt_f); end
  endtask

  task automatic test_priority;
    do_reset();
    set_issue(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    set_issue(1, 7, 1, 0, 0, 0, 0, 0);
    br_taken = 1'b1;
    #1;
    n_checks++; if (stall0 !== 1'b1 || flush0 !== 1'b0) begin
      n_fail++; $display("FAIL pri_stall_flush got %0d/%0d want 1/0", stall0, flush0); end
    n_checks++; if (flush_f !== 1'b0) begin n_fail++; $display("FAIL pri_flush_f got %0d want 0", flush_f); end
    n_checks++; if (flush_l !== 1'b1) begin n_fail++; $display("FAIL pri_legacy got %0d want 1", flush_l); end
    tick();
    br_taken = 1'b0;
    #1;
    n_checks++; if (flush_f !== 1'b0 || flush0 !== 1'b0) begin
      n_fail++; $display("FAIL pri_not_loaded got %0d/%0d want 0/0", flush_f, flush0); end
    n_checks++; if (sel_a0 !== 2'd2) begin n_fail++; $display("FAIL pri_fwd got %0d want 2", sel_a0); end
    n_checks++; if (fcnt_f !== 16'd0) begin n_fail++; $display("FAIL pri_count got %0d want 0", fcnt_f); end
  endtask

  task automatic test_saturation;
    // lw x7,0(x7) held: stalls on every odd cycle.
    do_reset();
    set_issue(1, 7, 1, 0, 0, 7, 1, 1);
    for (int i = 0; i < 30; i++) tick();
    n_checks++; if (scnt_s !== 4'd15) begin n_fail++; $display("FAIL sat_s30 got %0d want 15", scnt_s); end
    n_checks++; if (scnt0 !== 16'd15) begin n_fail++; $display("FAIL cnt_030 got %0d want 15", scnt0); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (scnt_s !== 4'd15) begin n_fail++; $display("FAIL sat_s40 got %0d want 15", scnt_s); end
    n_checks++; if (scnt0 !== 16'd20) begin n_fail++; $display("FAIL cnt_040 got %0d want 20", scnt0); end
    do_reset();
    br_taken = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (fcnt_s !== 4'd15) begin n_fail++; $display("FAIL sat_flush got %0d want 15", fcnt_s); end
    n_checks++; if (fcnt0 !== 16'd20) begin n_fail++; $display("FAIL cnt_flush got %0d want 20", fcnt0); end
    n_checks++; if (flush_s !== 1'b1) begin n_fail++; $display("FAIL sat_flush_hi got %0d want 1", flush_s); end
    br_taken = 1'b0;
  endtask

  initial begin
    br_taken = 1'b0;
    set_issue(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_x0_unused();
    test_multi_flush();
    test_priority();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
